data_cache: RTL and testbench

Direct-mapped, write-back, write-allocate data cache between the 8-bit CPU data port and the 32-bit-block data memory. It holds 8 lines of 4 bytes each. Hits are served without memory traffic. Misses evict a dirty victim, then refill the line from memory, stalling the CPU through `busywait`.

---
 rtl/data_cache_pkg.sv | 15 +
 rtl/data_cache.sv | 114 +++++++++++
 tb/tb_data_cache.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/data_cache_pkg.sv
// Shared geometry and FSM state encoding for the direct-mapped data cache.
package data_cache_pkg;
  localparam int TAG_W    = 3;
  localparam int INDEX_W  = 3;
  localparam int OFFSET_W = 2;
  localparam int LINES    = 8;
  localparam int BLOCK_W  = 32;

  typedef enum logic [1:0] {IDLE, WRITE_BACK, MEM_READ, UPDATE} state_t;

  function automatic logic [7:0] sel_byte(input logic [BLOCK_W-1:0] blk,
                                          input logic [OFFSET_W-1:0] off);
    return blk[{off, 3'b000} +: 8];
  endfunction
endpackage

// File: rtl/data_cache.sv
// Direct-mapped write-back/write-allocate cache, 8 lines x 4 bytes; hits complete
// with zero stall, misses stall via busywait through write-back and refill.
module data_cache
  import data_cache_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               read,
  input  logic               write,
  input  logic [7:0]         address,
  input  logic [7:0]         writedata,
  output logic [7:0]         readdata,
  output logic               busywait,
  output logic               mem_read,
  output logic               mem_write,
  input  logic               mem_busywait,
  output logic [5:0]         mem_address,
  output logic [BLOCK_W-1:0] mem_writedata,
  input  logic [BLOCK_W-1:0] mem_readdata
);

  logic [TAG_W-1:0]    tag;
  logic [INDEX_W-1:0]  idx;
  logic [OFFSET_W-1:0] off;

  logic [LINES-1:0]    valid;
  logic [LINES-1:0]    dirty;
  logic [TAG_W-1:0]    tags [LINES];
  logic [BLOCK_W-1:0]  data [LINES];
  logic [BLOCK_W-1:0]  fill;
  state_t              state;

  logic hit, req, idle_hit, write_hit;

  assign tag = address[7:5];
  assign idx = address[4:2];
  assign off = address[1:0];

  assign hit       = valid[idx] && (tags[idx] == tag);
  assign req       = read | write;
  assign idle_hit  = (state == IDLE) && hit;
  assign write_hit = idle_hit && write;

  // Gated by reset so the stall drops asynchronously even with a request held.
  assign busywait = reset && req && !idle_hit;
  assign readdata = (reset && read && idle_hit) ? sel_byte(data[idx], off) : 8'h00;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= IDLE;
      valid         <= '0;
      dirty         <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      mem_address   <= '0;
      mem_writedata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_hit) begin
            dirty[idx] <= 1'b1;
          end else if (req && !hit) begin
            if (valid[idx] && dirty[idx]) begin
              state         <= WRITE_BACK;
              mem_write     <= 1'b1;
              mem_address   <= {tags[idx], idx};
              mem_writedata <= data[idx];
            end else begin
              state       <= MEM_READ;
              mem_read    <= 1'b1;
              mem_address <= {tag, idx};
            end
          end
        end
        WRITE_BACK: begin
          if (!mem_busywait) begin
            state         <= MEM_READ;
            mem_write     <= 1'b0;
            mem_writedata <= '0;
            mem_read      <= 1'b1;
            mem_address   <= {tag, idx};
          end
        end
        MEM_READ: begin
          if (!mem_busywait) begin
            state       <= UPDATE;
            mem_read    <= 1'b0;
            mem_address <= '0;
          end
        end
        UPDATE: begin
          state      <= IDLE;
          valid[idx] <= 1'b1;
          dirty[idx] <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Tag/data arrays carry no reset; valid bits guard their contents.
  always_ff @(posedge clk) begin
    if (state == MEM_READ && !mem_busywait) begin
      fill <= mem_readdata;
    end
    if (state == UPDATE) begin
      data[idx] <= fill;
      tags[idx] <= tag;
    end else if (write_hit) begin
      data[idx][{off, 3'b000} +: 8] <= writedata;
    end
  end

endmodule

// File: tb/tb_data_cache.sv
// Directed scoreboard bench for data_cache against a 5-cycle-latency block memory.
module tb_data_cache;
  localparam int LAT = 5;

  logic        clk = 1'b0;
  logic        reset;
  logic        read, write;
  logic [7:0]  address, writedata, readdata;
  logic        busywait, mem_read, mem_write, mem_busywait;
  logic [5:0]  mem_address;
  logic [31:0] mem_writedata, mem_readdata;

  data_cache dut (
    .clk(clk), .reset(reset), .read(read), .write(write), .address(address),
    .writedata(writedata), .readdata(readdata), .busywait(busywait),
    .mem_read(mem_read), .mem_write(mem_write), .mem_busywait(mem_busywait),
    .mem_address(mem_address), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  // Memory model: busy from the cycle a request appears until its LAT-th cycle.
  logic [31:0] mem [64];
  logic        mem_init;
  int          mcnt;

  function automatic logic [31:0] base_block(input int i);
    logic [7:0] b;
    b = 8'(i);
    if (i == 1) return 32'hDDCCBBAA;
    if (i == 9) return 32'h44332211;
    return 32'hA0B0C0D0 ^ {b, b, b, b};
  endfunction

  assign mem_busywait = (mem_read | mem_write) && (mcnt != LAT - 1);
  assign mem_readdata = mem[mem_address];

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= base_block(i);
    end else if (mem_write && !mem_busywait) begin
      mem[mem_address] <= mem_writedata;
    end
  end

  always @(posedge clk or negedge reset) begin
    if (!reset) mcnt <= 0;
    else if ((mem_read | mem_write) && mem_busywait) mcnt <= mcnt + 1;
    else mcnt <= 0;
  end

  // Memory-traffic monitor, sampled on the falling edge.
  bit         saw_rd, saw_wr, saw_both;
  logic [5:0] rd_addr, wb_addr;
  logic [31:0] wb_data;

  always @(negedge clk) begin
    if (mem_read && mem_write) saw_both = 1'b1;
    if (mem_read && !saw_rd) begin saw_rd = 1'b1; rd_addr = mem_address; end
    if (mem_write && !saw_wr) begin
      saw_wr = 1'b1; wb_addr = mem_address; wb_data = mem_writedata;
    end
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: expected byte and stall pushed at issue, popped at completion.
  logic [7:0] exp_data_q [$];
  int         exp_stall_q [$];

  task automatic access(input string tag, input logic r, input logic w,
                        input logic [7:0] a, input logic [7:0] wd,
                        input logic [7:0] exp_data, input int exp_stall);
    int stall;
    logic [7:0] rd;
    logic [7:0] ed;
    int es;
    exp_data_q.push_back(exp_data);
    exp_stall_q.push_back(exp_stall);
    saw_rd = 0; saw_wr = 0;
    read = r; write = w; address = a; writedata = wd;
    stall = 0;
    rd = 8'h00;
    forever begin
      @(negedge clk);
      if (!busywait) begin rd = readdata; break; end
      stall++;
      if (stall > 200) begin
        chk({tag, "_timeout"}, 32'(stall), 32'(exp_stall));
        break;
      end
    end
    ed = exp_data_q.pop_front();
    es = exp_stall_q.pop_front();
    chk({tag, "_stall"}, 32'(stall), 32'(es));
    if (r && !w) chk({tag, "_data"}, {24'h0, rd}, {24'h0, ed});
    @(posedge clk);
    #1;
    read = 1'b0; write = 1'b0;
  endtask

  initial begin
    read = 1'b1; write = 1'b0; address = 8'h05; writedata = 8'h00;
    reset = 1'b0; mem_init = 1'b1;

    // Reset with a request held: everything must read as zero.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busywait", {31'h0, busywait}, 32'h0);
    chk("rst_mem_read", {31'h0, mem_read}, 32'h0);
    chk("rst_mem_write", {31'h0, mem_write}, 32'h0);
    chk("rst_readdata", {24'h0, readdata}, 32'h0);
    chk("rst_mem_addr", {26'h0, mem_address}, 32'h0);
    chk("rst_mem_wdata", mem_writedata, 32'h0);
    @(posedge clk); #1;
    read = 1'b0; mem_init = 1'b0; reset = 1'b1;
    @(posedge clk); #1;

    // First access after reset misses.
    access("rd00", 1, 0, 8'h00, 8'h00, 8'hD0, LAT + 2);
    chk("rd00_memrd", {31'h0, saw_rd}, 32'h1);
    chk("rd00_addr", {26'h0, rd_addr}, 32'h00);

    // Clean read miss.
    access("rd05", 1, 0, 8'h05, 8'h00, 8'hBB, LAT + 2);
    chk("rd05_addr", {26'h0, rd_addr}, 32'h01);
    chk("rd05_nowb", {31'h0, saw_wr}, 32'h0);

    access("rd07", 1, 0, 8'h07, 8'h00, 8'hDD, 0);
    chk("rd07_nomem", {30'h0, saw_rd, saw_wr}, 32'h0);

    // Write hit.
    access("wr06", 0, 1, 8'h06, 8'h5A, 8'h00, 0);
    chk("wr06_nomem", {30'h0, saw_rd, saw_wr}, 32'h0);
    chk("idle_readdata", {24'h0, readdata}, 32'h0);
    access("rd06", 1, 0, 8'h06, 8'h00, 8'h5A, 0);

    // Dirty eviction of index 1 by tag 1.
    access("rd26", 1, 0, 8'h26, 8'h00, 8'h33, 2 * LAT + 2);
    chk("ev_wb_seen", {31'h0, saw_wr}, 32'h1);
    chk("ev_wb_addr", {26'h0, wb_addr}, 32'h01);
    chk("ev_wb_data", wb_data, 32'hDD5ABBAA);
    chk("ev_rd_addr", {26'h0, rd_addr}, 32'h09);

    // Reset while refilling.
    read = 1'b1; address = 8'h05;
    @(negedge clk);
    @(negedge clk);
    chk("mid_mem_read", {31'h0, mem_read}, 32'h1);
    #1 reset = 1'b0;
    #1;
    chk("mid_rst_mem_read", {31'h0, mem_read}, 32'h0);
    chk("mid_rst_busywait", {31'h0, busywait}, 32'h0);
    chk("mid_rst_mem_addr", {26'h0, mem_address}, 32'h0);
    repeat (2) @(posedge clk);
    #1 read = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    access("rd05b", 1, 0, 8'h05, 8'h00, 8'hBB, LAT + 2);
    chk("rd05b_addr", {26'h0, rd_addr}, 32'h01);

    // Read and write together behave as a write; eviction proves dirty was set.
    access("rw04", 1, 1, 8'h04, 8'h77, 8'h00, 0);
    chk("rw04_nomem", {30'h0, saw_rd, saw_wr}, 32'h0);
    access("rd24", 1, 0, 8'h24, 8'h00, 8'h11, 2 * LAT + 2);
    chk("rw_wb_seen", {31'h0, saw_wr}, 32'h1);
    chk("rw_wb_data", wb_data, 32'hDD5ABB77);
    chk("rw_rd_addr", {26'h0, rd_addr}, 32'h09);

    chk("no_rd_wr_overlap", {31'h0, saw_both}, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
